ysyx_ifu: RTL
=============

Name: ysyx_ifu

Overview:
Multi-cycle instruction fetch unit, directly upstream of the decode stage and its immediate extender. Holds the PC and issues one read per instruction on the instruction bus (AR/R valid-ready channels). Presents the fetched word plus its PC to decode over a valid/ready handshake, then waits for the write-back stage to supply the next PC before fetching again. Non-pipelined: at most one instruction in flight.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, word presented on out_inst when a fetch faults

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
ibus_arvalid  out  1  read address valid
ibus_arready  in  1  read address accepted
ibus_araddr  out  32  fetch address (= pc)
ibus_rvalid  in  1  read data valid
ibus_rready  out  1  IFU ready for read data
ibus_rdata  in  32  instruction word
ibus_rresp  in  2  response code, 2'b00 = OKAY, any other value = error
out_valid  out  1  instruction valid to decode
out_ready  in  1  decode accepts instruction
out_inst  out  32  instruction word
out_pc  out  32  PC of out_inst
out_fault  out  2  00 none, 01 bus access fault, 10 misaligned PC
upd_valid  in  1  next PC valid from write-back
upd_ready  out  1  IFU accepts next PC
upd_pc  in  32  next PC

Behaviour:
- States: S_IDLE, S_REQ, S_RESP, S_OUT, S_WAIT. State, pc and the instruction register are registers. All handshake outputs decode from the state only, with no combinational input-to-output paths.
- Reset (rst_n=0 at an edge): state<=S_IDLE, pc<=RESET_PC, inst_r<=0, fault_r<=00. Reset mid-operation abandons any outstanding bus transaction. The bus slave shares the same reset.
- Outputs in S_IDLE: arvalid=rready=out_valid=upd_ready=0, out_fault=00, out_inst=0, out_pc=pc, araddr=pc.
- S_IDLE -> S_REQ unconditionally. The first arvalid rises in the 2nd cycle after rst_n deasserts.
- S_REQ: arvalid=1, araddr=pc. araddr and arvalid stay stable until arready. On arready, go to S_RESP. rvalid in S_REQ is ignored.
- S_RESP: rready=1. On rvalid, capture inst_r<=rdata and fault_r<=00 when rresp==00. Otherwise capture inst_r<=NOP_INST and fault_r<=01. Then go to S_OUT.
- S_OUT: out_valid=1, out_inst=inst_r, out_pc=pc, out_fault=fault_r. These values are held stable until out_ready. On out_ready, go to S_WAIT.
- S_WAIT: upd_ready=1. On upd_valid, pc<=upd_pc and go to S_REQ. upd_valid in any other state is ignored (upd_ready=0).
- Minimum latency with all peers ready: REQ, RESP, OUT, WAIT = 4 cycles per instruction.
- Zero-wait bus: arready in the first S_REQ cycle and rvalid in the first S_RESP cycle are legal and add no bubbles.
- pc wraps modulo 2^32. No arithmetic is performed on pc inside the block.
- The fault is reported, not handled. Decode/write-back own the trap. The IFU still waits in S_WAIT for the next PC.

Optional Feature:
YSYX_IFU_MISALIGN_CHECK_EN
- Defined: in S_WAIT, when upd_valid and upd_pc[1:0]!=00, load pc<=upd_pc, inst_r<=NOP_INST and fault_r<=10, then go directly to S_OUT. No bus request is issued for a misaligned PC.
- Undefined: upd_pc is loaded unchecked and fetched as-is. out_fault never reports 10.

Test Plan:
- Reset release, zero-wait bus returning 32'h0010_0093 -> arvalid with araddr=32'h8000_0000 in cycle 2. out_valid one cycle after the rvalid edge, with out_inst=32'h0010_0093, out_pc=32'h8000_0000, out_fault=00.
- Back-pressure: arready delayed 3 cycles, rvalid delayed 2, out_ready delayed 4 -> araddr, out_inst and out_pc stay stable throughout. Exactly one AR handshake and one R handshake per instruction.
- Redirect: in S_WAIT, upd_valid with upd_pc=32'h8000_0100 -> next araddr=32'h8000_0100. upd_valid pulses asserted in S_REQ, S_RESP or S_OUT are ignored and pc is unchanged.
- Bus error: rresp=2'b10 with rdata=32'hDEAD_BEEF -> out_inst=32'h0000_0013, out_fault=01. The IFU then accepts upd_pc normally.
- Reset mid-fetch: rst_n=0 while in S_RESP -> next cycle all valid/ready outputs are 0 and pc=32'h8000_0000. Fetch restarts from RESET_PC.
- With YSYX_IFU_MISALIGN_CHECK_EN defined, upd_pc=32'h8000_0102 -> no arvalid, out_valid with out_pc=32'h8000_0102 and out_fault=10. With it undefined, araddr=32'h8000_0102 is issued.

Source files
------------

// File: rtl/ysyx_ifu.sv
// Multi-cycle, non-pipelined instruction fetch unit: one AR/R read per instruction, hands the word to decode, then waits for the next PC.
// Optional misaligned-PC trap reporting is enabled with `define YSYX_IFU_MISALIGN_CHECK_EN.
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ibus_arvalid,
    input  logic        ibus_arready,
    output logic [31:0] ibus_araddr,
    input  logic        ibus_rvalid,
    output logic        ibus_rready,
    input  logic [31:0] ibus_rdata,
    input  logic [1:0]  ibus_rresp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [1:0]  out_fault,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_pc
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned FW   = 2;

    localparam logic [FW-1:0] FAULT_NONE     = FW'(0);
    localparam logic [FW-1:0] FAULT_BUS      = FW'(1);
    localparam logic [FW-1:0] RESP_OKAY      = FW'(0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_OUT,
        S_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q,    pc_d;
    logic [XLEN-1:0]   inst_q,  inst_d;
    logic [FW-1:0]     fault_q, fault_d;

    // State, PC and instruction register; reset abandons any bus transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // Next state and handshakes; every output decodes from registered state only.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        fault_d      = fault_q;
        ibus_arvalid = 1'b0;
        ibus_rready  = 1'b0;
        out_valid    = 1'b0;
        upd_ready    = 1'b0;
        ibus_araddr  = pc_q;
        out_pc       = pc_q;
        out_inst     = inst_q;
        out_fault    = fault_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                ibus_arvalid = 1'b1;
                if (ibus_arready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ibus_rready = 1'b1;
                if (ibus_rvalid) begin
                    if (ibus_rresp == RESP_OKAY) begin
                        inst_d  = ibus_rdata;
                        fault_d = FAULT_NONE;
                    end else begin
                        inst_d  = NOP_INST;
                        fault_d = FAULT_BUS;
                    end
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                upd_ready = 1'b1;
                if (upd_valid) begin
                    pc_d    = upd_pc;
                    state_d = S_REQ;
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
                    // Misaligned target: report it to decode without touching the bus.
                    if (upd_pc[1:0] != 2'b00) begin
                        inst_d  = NOP_INST;
                        fault_d = FW'(2);
                        state_d = S_OUT;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
